uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
Buffered, parametrised UART and the successor to the single-octet UART. It has independent TX and RX FIFOs, a configurable data width, optional parity, and sticky error reporting (overrun, parity, framing). Self-contained bit engines with no sub-module dependencies. It sits between the host logic and the async serial pins.

Parameters:
CLK_FREQ, 48_000_000, system clock frequency (Hz).
BIT_FREQ, 115_200, baud rate. DIV = CLK_FREQ/BIT_FREQ (integer division), DIV >= 4.
DATA_BITS, 8, bits per character. Legal range 5..8.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
TX_DEPTH_LOG2, 4, TX FIFO holds 2**TX_DEPTH_LOG2 words.
RX_DEPTH_LOG2, 4, RX FIFO holds 2**RX_DEPTH_LOG2 words.

Ports:
clk  in  1  system clock; every register updates on the rising edge.
rst  in  1  synchronous, active-high reset.
tx_data  in  DATA_BITS  word to transmit.
wr  in  1  push tx_data into the TX FIFO.
tx_full  out  1  TX FIFO full.
tx_empty  out  1  TX FIFO empty and TX engine idle.
rx_data  out  DATA_BITS  head of the RX FIFO (first-word fall-through).
rd  in  1  pop the RX FIFO head.
valid  out  1  RX FIFO non-empty.
break  out  1  line-break condition.
overrun  out  1  sticky: a received word was dropped because the RX FIFO was full.
parity_err  out  1  sticky: parity mismatch seen.
frame_err  out  1  sticky: stop bit sampled low on a non-break frame.
clr_err  in  1  clears overrun, parity_err and frame_err.
rx  in  1  serial receive line (async).
tx  out  1  serial transmit line.

Behaviour:
- Reset (one cycle of rst=1):
  - Both FIFOs are emptied and both engines go to IDLE.
  - tx=1, tx_full=0, tx_empty=1, valid=0, rx_data=0, break=0, all sticky flags 0.
  - Reset mid-frame aborts the frame. tx is high on the cycle after the reset edge.
- TX FIFO:
  - wr while tx_full=0 pushes tx_data. wr while tx_full=1 is ignored and the word is lost.
  - A push and an engine pop in the same cycle leave the count unchanged.
- TX engine:
  - States: IDLE, START, DATA, PAR, STOP.
  - In IDLE with the FIFO non-empty, the engine pops the head at that edge and enters START. Pop latency is one cycle after the push.
  - Each state lasts DIV cycles.
  - START drives 0. DATA drives DATA_BITS bits, LSB first. PAR (only when PARITY != 0) drives the parity bit. STOP drives 1.
  - After STOP, the engine returns to IDLE, or loads the next word immediately so back-to-back frames have exactly one stop bit.
  - Parity bit: even = XOR of the data bits; odd = its inverse.
- RX front end:
  - rx passes through a 2-flop synchroniser (reset value 1).
  - A falling edge while IDLE starts a frame.
  - The start bit is resampled at DIV/2. If it is high there, the engine returns to IDLE (glitch rejection).
  - Data, parity and stop bits are then sampled every DIV cycles.
- RX frame completion:
  - Stop bit = 1: push the word. If parity mismatches, the word is still pushed and parity_err is set.
  - Stop bit = 0 with all data bits 0: no push; break=1. break stays 1 until the synchronised rx is high, then the receiver returns to IDLE.
  - Stop bit = 0 otherwise: no push; frame_err=1.
- RX FIFO and rd:
  - A push when full (and no simultaneous rd) drops the new word and sets overrun.
  - Push plus rd when full is accepted.
  - rd when valid=0 is ignored.
  - rx_data is 0 when empty.
- Sticky flags:
  - clr_err clears them.
  - If a set event and clr_err coincide, set wins.

Test Plan:
- CLK_FREQ=16, BIT_FREQ=1 (DIV=16), tx looped to rx; write 0x55 then 0xA3 -> tx low 16 cycles, then bits 1,0,1,0,1,0,1,0, then high 16 cycles; rx_data yields 0x55 then 0xA3, valid=1; no flags set.
- TX_DEPTH_LOG2=2; wr 0x01..0x06 on six consecutive cycles -> tx_full=1 on cycle 5; 0x06 ignored; 0x01..0x05 transmitted in order; tx_empty=1 afterwards.
- PARITY=2; drive rx frame 0x07 with parity bit 0 -> rx_data=0x07 pushed, parity_err=1; pulse clr_err -> parity_err=0.
- RX_DEPTH_LOG2=2; send 5 frames 0x10..0x14 with no rd -> 4 words buffered, overrun=1; four rd pops return 0x10..0x13, then valid=0.
- Hold rx=0 for 40 bit times, then release -> break=1 from the stop-bit sample until rx high; no word pushed; frame_err=0.
- Assert rst during data bit 3 of a TX frame while the RX FIFO holds 2 words -> next cycle tx=1, valid=0, tx_empty=1, all flags 0.

Source files
------------

// File: rtl/uart_fifo.sv
// Buffered UART with TX/RX FIFOs, optional parity and sticky error flags. TX pops one cycle after a push.
// Writes are dropped when the TX FIFO is full; RX words are dropped (and overrun set) when the RX FIFO is full.
module uart_fifo #(
    parameter int CLK_FREQ      = 48_000_000,
    parameter int BIT_FREQ      = 115_200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 wr,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rd,
    output logic                 valid,
    output logic                 line_break,
    output logic                 overrun,
    output logic                 parity_err,
    output logic                 frame_err,
    input  logic                 clr_err,
    input  logic                 rx,
    output logic                 tx
);

    localparam int DIV = CLK_FREQ / BIT_FREQ;
    localparam int CW  = $clog2(DIV);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int TXD = 1 << TX_DEPTH_LOG2;
    localparam int RXD = 1 << RX_DEPTH_LOG2;
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0]   txq [TXD];
    logic [TX_DEPTH_LOG2-1:0] txq_wp, txq_rp;
    logic [TX_DEPTH_LOG2:0]   txq_cnt;
    logic                     tx_push, tx_pop;

    assign tx_full = (txq_cnt == (TX_DEPTH_LOG2+1)'(TXD));
    assign tx_push = wr && !tx_full;

    always_ff @(posedge clk) begin
        if (tx_push) txq[txq_wp] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txq_wp  <= '0;
            txq_rp  <= '0;
            txq_cnt <= '0;
        end else begin
            if (tx_push) txq_wp <= txq_wp + 1'b1;
            if (tx_pop)  txq_rp <= txq_rp + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   txq_cnt <= txq_cnt + 1'b1;
                2'b01:   txq_cnt <= txq_cnt - 1'b1;
                default: txq_cnt <= txq_cnt;
            endcase
        end
    end

    // ---------------- TX engine ----------------
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
    tx_state_t            tx_state, tx_state_n;
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par, tx_tick, tx_line;

    assign tx_tick  = (tx_cnt == DIV_LAST);
    assign tx       = tx_line;
    assign tx_empty = (txq_cnt == '0) && (tx_state == T_IDLE);

    always_ff @(posedge clk) begin
        if (rst) tx_state <= T_IDLE;
        else     tx_state <= tx_state_n;
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
        case (tx_state)
            T_IDLE: begin
                if (txq_cnt != '0) begin
                    tx_pop     = 1'b1;
                    tx_state_n = T_START;
                end
            end
            T_START: begin
                tx_line = 1'b0;
                if (tx_tick) tx_state_n = T_DATA;
            end
            T_DATA: begin
                tx_line = tx_sh[0];
                if (tx_tick && tx_bit == BIT_LAST)
                    tx_state_n = (PARITY != 0) ? T_PAR : T_STOP;
            end
            T_PAR: begin
                tx_line = tx_par;
                if (tx_tick) tx_state_n = T_STOP;
            end
            T_STOP: begin
                // Reload straight from STOP so consecutive frames share exactly one stop bit.
                if (tx_tick) begin
                    if (txq_cnt != '0) begin
                        tx_pop     = 1'b1;
                        tx_state_n = T_START;
                    end else begin
                        tx_state_n = T_IDLE;
                    end
                end
            end
            default: tx_state_n = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            tx_par <= 1'b0;
        end else if (tx_pop) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= txq[txq_rp];
            tx_par <= (PARITY == 1) ? ~^txq[txq_rp] : ^txq[txq_rp];
        end else if (tx_state != T_IDLE) begin
            if (tx_tick) begin
                tx_cnt <= '0;
                if (tx_state == T_DATA) begin
                    tx_sh  <= tx_sh >> 1;
                    tx_bit <= tx_bit + 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // ---------------- RX front end ----------------
    logic [1:0] rx_sync;
    logic       rx_s, rx_prev;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
        end
    end

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK} rx_state_t;
    rx_state_t            rx_state, rx_state_n;
    logic [CW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_bit;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_par, rx_tick, rx_push, par_bad, frm_set;

    assign rx_tick    = (rx_cnt == ((rx_state == R_START) ? HALF_LAST : DIV_LAST));
    assign line_break = (rx_state == R_BRK);

    always_ff @(posedge clk) begin
        if (rst) rx_state <= R_IDLE;
        else     rx_state <= rx_state_n;
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_push    = 1'b0;
        par_bad    = 1'b0;
        frm_set    = 1'b0;
        case (rx_state)
            R_IDLE:  if (rx_prev && !rx_s) rx_state_n = R_START;
            R_START: if (rx_tick) rx_state_n = rx_s ? R_IDLE : R_DATA;
            R_DATA: begin
                if (rx_tick && rx_bit == BIT_LAST)
                    rx_state_n = (PARITY != 0) ? R_PAR : R_STOP;
            end
            R_PAR:   if (rx_tick) rx_state_n = R_STOP;
            R_STOP: begin
                if (rx_tick) begin
                    if (rx_s) begin
                        rx_state_n = R_IDLE;
                        rx_push    = 1'b1;
                        par_bad    = (PARITY != 0) &&
                                     (rx_par != ((PARITY == 1) ? ~^rx_sh : ^rx_sh));
                    end else if (rx_sh == '0) begin
                        rx_state_n = R_BRK;
                    end else begin
                        rx_state_n = R_IDLE;
                        frm_set    = 1'b1;
                    end
                end
            end
            R_BRK:   if (rx_s) rx_state_n = R_IDLE;
            default: rx_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
            rx_par <= 1'b0;
        end else begin
            if (rx_state == R_IDLE || rx_state == R_BRK || rx_tick) rx_cnt <= '0;
            else                                                  rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == R_START) rx_bit <= '0;
            if (rx_state == R_DATA && rx_tick) begin
                rx_sh  <= {rx_s, rx_sh[DATA_BITS-1:1]};
                rx_bit <= rx_bit + 1'b1;
            end
            if (rx_state == R_PAR && rx_tick) rx_par <= rx_s;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0]     rxq [RXD];
    logic [RX_DEPTH_LOG2-1:0] rxq_wp, rxq_rp;
    logic [RX_DEPTH_LOG2:0]   rxq_cnt;
    logic                     rx_full, rx_pop, rx_acc, ovr_set;

    assign valid   = (rxq_cnt != '0);
    assign rx_full = (rxq_cnt == (RX_DEPTH_LOG2+1)'(RXD));
    assign rx_pop  = rd && valid;
    assign rx_acc  = rx_push && (!rx_full || rx_pop);
    assign ovr_set = rx_push && rx_full && !rx_pop;
    assign rx_data = valid ? rxq[rxq_rp] : '0;

    always_ff @(posedge clk) begin
        if (rx_acc) rxq[rxq_wp] <= rx_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxq_wp  <= '0;
            rxq_rp  <= '0;
            rxq_cnt <= '0;
        end else begin
            if (rx_acc) rxq_wp <= rxq_wp + 1'b1;
            if (rx_pop) rxq_rp <= rxq_rp + 1'b1;
            case ({rx_acc, rx_pop})
                2'b10:   rxq_cnt <= rxq_cnt + 1'b1;
                2'b01:   rxq_cnt <= rxq_cnt - 1'b1;
                default: rxq_cnt <= rxq_cnt;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overrun    <= ovr_set | (overrun    & ~clr_err);
            parity_err <= par_bad | (parity_err & ~clr_err);
            frame_err  <= frm_set | (frame_err  & ~clr_err);
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: DIV=16, even parity, 4-deep FIFOs, optional tx->rx loopback.
module tb_uart_fifo;

    logic       clk = 1'b0;
    logic       rst, wr, rd, clr_err, rx_drv, loop;
    logic [7:0] tx_data, rx_data;
    logic       tx_full, tx_empty, valid, line_break, overrun, parity_err, frame_err, tx, rx_line;
    int         checks = 0;
    int         errors = 0;

    assign rx_line = loop ? tx : rx_drv;

    uart_fifo #(
        .CLK_FREQ(16), .BIT_FREQ(1), .DATA_BITS(8), .PARITY(2),
        .TX_DEPTH_LOG2(2), .RX_DEPTH_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .wr(wr), .tx_full(tx_full),
        .tx_empty(tx_empty), .rx_data(rx_data), .rd(rd), .valid(valid),
        .line_break(line_break), .overrun(overrun), .parity_err(parity_err),
        .frame_err(frame_err), .clr_err(clr_err), .rx(rx_line), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one serial frame on tx; b2b means the start bit must already be on the line.
    task automatic check_frame(input logic [7:0] d, input bit b2b, input int skip);
        logic [10:0] bits;
        int          n, bad;
        bits = {1'b1, ^d, d, 1'b0};
        if (b2b) begin
            check($sformatf("frame_%02h_b2b_start", d), {31'b0, tx}, 0);
        end else begin
            n = 0;
            while (tx !== 1'b0 && n < 400) begin
                tick();
                n++;
            end
            check($sformatf("frame_%02h_fall", d), {31'b0, tx}, 0);
        end
        for (int j = 0; j < 11; j++) begin
            bad = 0;
            for (int c = (j == 0) ? skip : 0; c < 16; c++) begin
                if (j == 5 && c == 0) check("tx_busy_empty", {31'b0, tx_empty}, 0);
                if (tx !== bits[j]) bad++;
                tick();
            end
            check($sformatf("frame_%02h_bit%0d_badcycles", d, j), bad, 0);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int j = 0; j < 11; j++) begin
            rx_drv = bits[j];
            repeat (16) tick();
        end
        rx_drv = 1'b1;
        repeat (4) tick();
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] w;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; rx_drv = 1'b1; loop = 1'b0;
        tx_data = 8'h00;
        tick();
        rst = 1'b0;
        check("rst_tx", {31'b0, tx}, 1);
        check("rst_tx_full", {31'b0, tx_full}, 0);
        check("rst_tx_empty", {31'b0, tx_empty}, 1);
        check("rst_valid", {31'b0, valid}, 0);
        check("rst_rx_data", {24'b0, rx_data}, 0);
        check("rst_flags", {28'b0, line_break, overrun, parity_err, frame_err}, 0);

        // Loopback: two back-to-back frames, received in order.
        loop = 1'b1;
        tx_data = 8'h55; wr = 1'b1;
        tick();
        tx_data = 8'hA3;
        tick();
        wr = 1'b0;
        check_frame(8'h55, 1'b1, 0);
        check_frame(8'hA3, 1'b1, 0);
        check("loop_tx_idle", {31'b0, tx}, 1);
        check("loop_tx_empty", {31'b0, tx_empty}, 1);
        check("loop_valid", {31'b0, valid}, 1);
        check("loop_rx0", {24'b0, rx_data}, 32'h55);
        pop();
        check("loop_rx1", {24'b0, rx_data}, 32'hA3);
        pop();
        check("loop_valid_after", {31'b0, valid}, 0);
        check("loop_flags", {28'b0, line_break, overrun, parity_err, frame_err}, 0);
        loop = 1'b0;
        repeat (20) tick();

        // TX FIFO fill: first word is popped at the second edge, so full after the fifth write.
        for (int i = 1; i <= 6; i++) begin
            tx_data = 8'(i); wr = 1'b1;
            tick();
            check($sformatf("tx_full_after_wr%0d", i), {31'b0, tx_full}, (i >= 5) ? 1 : 0);
        end
        wr = 1'b0;
        check_frame(8'h01, 1'b1, 4);
        for (int i = 2; i <= 5; i++) check_frame(8'(i), 1'b1, 0);
        check("fill_tx_empty", {31'b0, tx_empty}, 1);
        check("fill_tx_full", {31'b0, tx_full}, 0);
        n = 0;
        repeat (40) begin
            if (tx !== 1'b1) n++;
            tick();
        end
        check("fill_word6_dropped", n, 0);

        // Even parity with a wrong parity bit: word kept, parity_err set.
        send_frame(8'h07, 1'b0, 1'b1);
        check("par_valid", {31'b0, valid}, 1);
        check("par_rx_data", {24'b0, rx_data}, 32'h07);
        check("par_err_set", {31'b0, parity_err}, 1);
        check("par_frame_err", {31'b0, frame_err}, 0);
        pulse_clr();
        check("par_err_clr", {31'b0, parity_err}, 0);
        pop();
        check("par_valid_after", {31'b0, valid}, 0);

        // Overrun: five frames into a four-word FIFO.
        for (int i = 0; i < 5; i++) begin
            w = 8'h10 + 8'(i);
            send_frame(w, ^w, 1'b1);
            if (i == 3) check("ovr_not_yet", {31'b0, overrun}, 0);
        end
        check("ovr_set", {31'b0, overrun}, 1);
        check("ovr_parity_ok", {31'b0, parity_err}, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovr_pop%0d", k), {24'b0, rx_data}, 32'h10 + k);
            pop();
        end
        check("ovr_valid_after", {31'b0, valid}, 0);
        check("ovr_rx_data_empty", {24'b0, rx_data}, 0);
        pulse_clr();
        check("ovr_clr", {31'b0, overrun}, 0);

        // Framing error: non-zero data with a low stop bit.
        send_frame(8'h21, ^8'h21, 1'b0);
        check("frm_err_set", {31'b0, frame_err}, 1);
        check("frm_no_push", {31'b0, valid}, 0);
        check("frm_no_break", {31'b0, line_break}, 0);
        pulse_clr();
        check("frm_err_clr", {31'b0, frame_err}, 0);

        // Break: line low for 40 bit times.
        rx_drv = 1'b0;
        repeat (5 * 16) tick();
        check("brk_before_stop", {31'b0, line_break}, 0);
        repeat (10 * 16) tick();
        check("brk_set", {31'b0, line_break}, 1);
        check("brk_no_push", {31'b0, valid}, 0);
        repeat (25 * 16) tick();
        check("brk_held", {31'b0, line_break}, 1);
        rx_drv = 1'b1;
        repeat (4) tick();
        check("brk_released", {31'b0, line_break}, 0);
        check("brk_valid", {31'b0, valid}, 0);
        check("brk_frame_err", {31'b0, frame_err}, 0);

        // Reset during TX data bit 3 with two RX words buffered and a flag raised.
        send_frame(8'h31, ^8'h31, 1'b1);
        send_frame(8'h32, ^8'h32, 1'b1);
        send_frame(8'h21, ^8'h21, 1'b0);
        check("pre_rst_valid", {31'b0, valid}, 1);
        check("pre_rst_frame_err", {31'b0, frame_err}, 1);
        tx_data = 8'h52; wr = 1'b1;
        tick();
        wr = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check("rst_frame_started", {31'b0, tx}, 0);
        repeat (4 * 16 + 8) tick();
        check("mid_bit3_tx", {31'b0, tx}, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_tx", {31'b0, tx}, 1);
        check("abort_valid", {31'b0, valid}, 0);
        check("abort_rx_data", {24'b0, rx_data}, 0);
        check("abort_tx_empty", {31'b0, tx_empty}, 1);
        check("abort_tx_full", {31'b0, tx_full}, 0);
        check("abort_flags", {28'b0, line_break, overrun, parity_err, frame_err}, 0);
        n = 0;
        repeat (40) begin
            if (tx !== 1'b1 || tx_empty !== 1'b1) n++;
            tick();
        end
        check("abort_stays_idle", n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
